periph_bus_initiator: RTL
=========================

Name: periph_bus_initiator

Overview:
- Initiator (master) end of the cluster peripheral bus (XBAR_PERIPH_BUS req/add/wen/wdata/be/id -> gnt, r_valid/r_opc/r_id/r_rdata).
- Accepts single-word commands on a valid/ready port, drives bus requests, and returns in-order responses through a buffered valid/ready port.
- Used by cluster-side agents (lockstep control, test/debug sequencers) to reach peripheral slaves such as the lockstep unit and the timer.

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width; BE width is DATA_WIDTH/8
- ID_WIDTH, 5, transaction ID width
- MAX_OUT, 2, response buffer depth = max reserved transactions (>=1)
- TIMEOUT_CYCLES, 256, grant-to-r_valid limit (optional feature only)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_wen_i  in  1  1=read, 0=write (bus convention)
- cmd_addr_i  in  ADDR_WIDTH  address
- cmd_wdata_i  in  DATA_WIDTH  write data
- cmd_be_i  in  DATA_WIDTH/8  byte enables
- periph_req_o  out  1  bus request
- periph_add_o  out  ADDR_WIDTH  bus address
- periph_wen_o  out  1  bus wen
- periph_wdata_o  out  DATA_WIDTH  bus write data
- periph_be_o  out  DATA_WIDTH/8  bus byte enables
- periph_id_o  out  ID_WIDTH  bus ID
- periph_gnt_i  in  1  grant
- periph_r_valid_i  in  1  response valid
- periph_r_opc_i  in  1  response error
- periph_r_id_i  in  ID_WIDTH  response ID
- periph_r_rdata_i  in  DATA_WIDTH  response data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data (write: as returned by slave)
- rsp_err_o  out  1  r_opc | ID mismatch | timeout
- spurious_o  out  1  sticky: r_valid seen with nothing outstanding

Behaviour:
- Reset (rst_i high at an edge): periph_req_o=0, all periph_* data outputs 0, id counter 0, outstanding=0, response FIFO empty (rsp_valid_o=0), spurious_o=0, cmd_ready_o=1 in the following cycle. Takes effect mid-transaction; in-flight transactions are abandoned.
- Request register req_q holds add/wen/wdata/be/id. Asserted request stays stable until the cycle with periph_req_o & periph_gnt_i.
- reserved = req_q + outstanding + rsp_count.
- cmd_ready_o = (!req_q | periph_gnt_i) & (reserved < MAX_OUT). It is combinational from gnt. A same-cycle response pop does not bypass the credit check.
- On accept, the request register loads the command and periph_req_o=1 next cycle. ID = id counter, which increments mod 2^ID_WIDTH per accepted command. Back-to-back: gnt and accept in the same cycle keep req high with the new payload.
- Grant: req_q clears unless a new command loads. Issued ID is pushed into the expected-ID FIFO (depth MAX_OUT); outstanding += 1.
- Response: r_valid with outstanding>0 pops expected ID and pushes {r_rdata, r_opc | (r_id != expected)} into the response FIFO; outstanding -= 1. Minimum latency: gnt at cycle N, r_valid at N+1, rsp_valid_o at N+2 (registered FIFO output).
- r_valid with outstanding==0: discarded, spurious_o set until reset.
- Simultaneous gnt and r_valid: both processed; outstanding unchanged.
- Response FIFO never overflows, by construction of the credit rule. rsp_* outputs stay stable while rsp_valid_o & !rsp_ready_i.
- States, derived from req_q/outstanding: IDLE (none) -> REQ (req_q) -> WAIT (outstanding>0, !req_q) -> IDLE. REQ and WAIT may coexist when MAX_OUT>1.

Optional Feature:
- Macro: PERIPH_INIT_TIMEOUT_EN.
- With it: a counter runs while outstanding>0 and resets on each r_valid. On reaching TIMEOUT_CYCLES:
  - push response {rdata=0, err=1}, pop expected ID, outstanding -= 1;
  - drop_cnt += 1; the next drop_cnt r_valids are discarded and do not set spurious_o.
- Without it: no counter or drop logic; the initiator waits indefinitely.

Decomposition:
- Package periph_init_pkg:
  - rsp_t struct {rdata, err};
  - default widths;
  - cnt_t sized $clog2(MAX_OUT+1).
- Sub-module periph_init_fifo: parameterised-type synchronous FIFO with sync active-high reset and full/empty/count outputs. Instantiated twice, for expected IDs and for responses.

Test Plan:
- Single read: cmd addr 0x1020_0000 wen=1; gnt same cycle as req; r_valid next cycle, rdata 0xDEAD_BEEF, id 0, opc 0 -> rsp_valid_o 2 cycles after gnt with 0xDEAD_BEEF, err 0; id of next cmd = 1.
- Grant stall: hold gnt low 5 cycles on write 0xA5A5_0001, be 0xF -> req/add/wdata/id stable all 5 cycles; exactly one transaction issued.
- Credit backpressure: MAX_OUT=2, rsp_ready_i=0, 3 commands -> third sees cmd_ready_o=0 until one response popped; no FIFO overflow.
- Error paths: r_opc=1 -> err 1; r_id=3 when 2 expected -> err 1, rdata passed through.
- Spurious/reset: reset asserted while outstanding=1, then r_valid -> spurious_o=1, rsp_valid_o stays 0, periph_req_o=0 the cycle after reset.
- Timeout (PERIPH_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=8): no r_valid for 8 cycles after gnt -> err response with rdata 0; late r_valid at cycle 12 discarded, spurious_o stays 0.

Source files
------------

// File: rtl/periph_init_pkg.sv
// Shared definitions for the peripheral bus initiator slice.
//
// Contents:
//   DEF_*      default widths and depths, used as module parameter defaults
//   rsp_t      response record {rdata, err} at the default data width
//   cnt_t      occupancy counter sized for DEF_MAX_OUT entries
//   state_t    initiator activity state (request pending / responses awaited)
//   cnt_bits() width of a counter that must hold the values 0..n
//
// The optional grant-to-response timeout is enabled by defining the macro
// PERIPH_INIT_TIMEOUT_EN (see periph_bus_initiator.sv).

package periph_init_pkg;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ID_WIDTH       = 5;
  localparam int DEF_MAX_OUT        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Counter width able to represent 0..n inclusive (at least one bit).
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } rsp_t;

  typedef logic [$clog2(DEF_MAX_OUT + 1)-1:0] cnt_t;

  // Bit 0: a request is held in the request register.
  // Bit 1: at least one granted transaction still awaits its response.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REQ      = 2'b01,
    ST_WAIT     = 2'b10,
    ST_REQ_WAIT = 2'b11
  } state_t;

endpackage

// File: rtl/periph_init_fifo.sv
// Small synchronous FIFO with a parameterised element type.
//
// The read side is taken straight from the storage array, so an entry
// written at a clock edge becomes visible at the output after that edge.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   push/wdata write strobe and data
//   pop        removes the head entry
//   rdata      head entry (valid while !empty)
//   full/empty occupancy flags
//   count      number of stored entries

module periph_init_fifo
  import periph_init_pkg::*;
#(
  parameter type T     = rsp_t,
  parameter int  DEPTH = DEF_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_bits(DEPTH)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_bits(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array: written on push, never reset since entries are only
  // observed while the FIFO reports them as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/periph_bus_initiator.sv
// Initiator end of the cluster peripheral bus.
//
// Takes single-word commands on a valid/ready port, drives one bus request
// at a time, tracks issued IDs in order and returns responses through a
// buffered valid/ready port. The number of transactions in flight
// (request register + granted-awaiting-response + buffered responses) is
// limited to MAX_OUT, so the response buffer can never overflow.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_*                   command port (cmd_wen_i: 1=read, 0=write)
//   periph_req/add/wen/wdata/be/id_o   bus request channel
//   periph_gnt_i            bus grant
//   periph_r_valid/opc/id/rdata_i      bus response channel
//   rsp_valid_o/rsp_ready_i response port, rsp_rdata_o / rsp_err_o
//   spurious_o              sticky: response seen with nothing outstanding
//
// Optional feature (macro PERIPH_INIT_TIMEOUT_EN): a response that has not
// arrived TIMEOUT_CYCLES after the oldest grant is completed locally with an
// error, and the matching late response is silently discarded later.

module periph_bus_initiator
  import periph_init_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int MAX_OUT        = DEF_MAX_OUT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_wen_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  output logic                    periph_req_o,
  output logic [ADDR_WIDTH-1:0]   periph_add_o,
  output logic                    periph_wen_o,
  output logic [DATA_WIDTH-1:0]   periph_wdata_o,
  output logic [DATA_WIDTH/8-1:0] periph_be_o,
  output logic [ID_WIDTH-1:0]     periph_id_o,
  input  logic                    periph_gnt_i,
  input  logic                    periph_r_valid_i,
  input  logic                    periph_r_opc_i,
  input  logic [ID_WIDTH-1:0]     periph_r_id_i,
  input  logic [DATA_WIDTH-1:0]   periph_r_rdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    spurious_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W    = cnt_bits(MAX_OUT);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_w_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] add_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ID_WIDTH-1:0]   id_cnt_q;
  logic                  spurious_q;

  logic                  req_valid;
  logic                  grant;
  logic                  accept;
  logic                  req_next;
  logic [CNT_W-1:0]      out_cnt;
  logic [CNT_W-1:0]      rsp_cnt;
  logic [ID_WIDTH-1:0]   exp_id;
  int                    reserved;
  int                    out_next;

  logic                  r_ok;
  logic                  r_spurious;
  logic                  pop_id;
  logic                  timeout_fire;
  logic                  drop_now;
  rsp_w_t                rsp_in;
  rsp_w_t                rsp_out;
  logic                  rsp_empty;
  logic                  unused_id_full;
  logic                  unused_id_empty;
  logic                  unused_rsp_full;

  assign req_valid = state_q[0];
  assign grant     = req_valid & periph_gnt_i;

  // Every in-flight transaction holds a credit from acceptance until its
  // response leaves the buffer; a grant or a same-cycle pop frees nothing.
  assign reserved    = 32'(req_valid) + 32'(out_cnt) + 32'(rsp_cnt);
  assign cmd_ready_o = (~req_valid | periph_gnt_i) & (reserved < MAX_OUT);
  assign accept      = cmd_valid_i & cmd_ready_o;

  // Response classification; dropped late responses bypass everything.
  assign r_ok       = periph_r_valid_i & ~drop_now & (out_cnt != '0);
  assign r_spurious = periph_r_valid_i & ~drop_now & (out_cnt == '0);
  assign pop_id     = r_ok | timeout_fire;

  // A timed-out transaction completes with zero data and an error flag.
  always_comb begin
    rsp_in = '0;
    if (timeout_fire) begin
      rsp_in.rdata = '0;
      rsp_in.err   = 1'b1;
    end else begin
      rsp_in.rdata = periph_r_rdata_i;
      rsp_in.err   = periph_r_opc_i | (periph_r_id_i != exp_id);
    end
  end

  assign req_next = accept | (req_valid & ~periph_gnt_i);
  assign out_next = 32'(out_cnt) + 32'(grant) - 32'(pop_id);

  // Main control: request register, ID counter, sticky spurious flag and
  // the activity state, which encodes {responses awaited, request held}.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      add_q      <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      id_q       <= '0;
      id_cnt_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (accept) begin
        add_q    <= cmd_addr_i;
        wen_q    <= cmd_wen_i;
        wdata_q  <= cmd_wdata_i;
        be_q     <= cmd_be_i;
        id_q     <= id_cnt_q;
        id_cnt_q <= id_cnt_q + 1'b1;
      end
      if (r_spurious) begin
        spurious_q <= 1'b1;
      end
      case ({out_next != 0, req_next})
        2'b00:   state_q <= ST_IDLE;
        2'b01:   state_q <= ST_REQ;
        2'b10:   state_q <= ST_WAIT;
        default: state_q <= ST_REQ_WAIT;
      endcase
    end
  end

  // In-order list of IDs granted but not yet answered; its occupancy is
  // the outstanding count.
  periph_init_fifo #(
    .T     (logic [ID_WIDTH-1:0]),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .wdata (id_q),
    .pop   (pop_id),
    .rdata (exp_id),
    .full  (unused_id_full),
    .empty (unused_id_empty),
    .count (out_cnt)
  );

  // Buffered responses waiting for the consumer.
  periph_init_fifo #(
    .T     (rsp_w_t),
    .DEPTH (MAX_OUT)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (pop_id),
    .wdata (rsp_in),
    .pop   (rsp_ready_i & ~rsp_empty),
    .rdata (rsp_out),
    .full  (unused_rsp_full),
    .empty (rsp_empty),
    .count (rsp_cnt)
  );

`ifdef PERIPH_INIT_TIMEOUT_EN
  localparam int TMR_W = cnt_bits(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] tmr_q;
  logic [7:0]       drop_q;

  // The timer fires on the TIMEOUT_CYCLES-th consecutive cycle with work
  // outstanding and no response; an arriving response always wins.
  assign timeout_fire = (out_cnt != '0) & ~periph_r_valid_i &
                        (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign drop_now     = periph_r_valid_i & (drop_q != '0);

  // Timeout timer plus the count of late responses still to be discarded
  // (saturating, so it can never wrap back to zero).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmr_q  <= '0;
      drop_q <= '0;
    end else begin
      if (periph_r_valid_i || (out_cnt == '0) || timeout_fire) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + 1'b1;
      end
      if (timeout_fire && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 1'b1;
      end else if (drop_now) begin
        drop_q <= drop_q - 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_fire   = 1'b0;
  assign drop_now       = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign periph_req_o   = req_valid;
  assign periph_add_o   = add_q;
  assign periph_wen_o   = wen_q;
  assign periph_wdata_o = wdata_q;
  assign periph_be_o    = be_q;
  assign periph_id_o    = id_q;

  assign rsp_valid_o = ~rsp_empty;
  assign rsp_rdata_o = rsp_out.rdata;
  assign rsp_err_o   = rsp_out.err;
  assign spurious_o  = spurious_q;

endmodule
